qr_row_feeder: RTL and testbench

Upstream stage of the 4-column Givens-rotation QR array. It accepts one matrix row (four signed elements) per beat over a valid/ready stream and buffers up to ROWS_MAX rows. It then clears the array, streams the rows back-to-back on the array's four lane inputs, and flags the final row with `last_end`. It holds off the next matrix until the array reports completion.

---
 rtl/qr_row_feeder_if.sv | 24 ++
 rtl/qr_row_feeder.sv | 196 +++++++++++++++++++
 tb/tb_qr_row_feeder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qr_row_feeder_if.sv
// Row stream from the upstream producer into qr_row_feeder.
// One beat carries a whole matrix row: four DW-bit lanes packed A (LSBs) to D.
interface qr_row_feeder_if #(
    parameter int DW = 13
);
    logic            s_valid;
    logic            s_ready;
    logic [4*DW-1:0] s_data;
    logic            s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/qr_row_feeder.sv
// Buffers one matrix of rows, clears the Givens QR array, streams the rows
// (zero-padded to at least four) onto its lanes, then waits for completion.
module qr_row_feeder #(
    parameter int DW       = 13,
    parameter int ROWS_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    qr_row_feeder_if.slave       s_if,
    output logic                 o_qr_rst_n,
    output logic [DW-1:0]        o_data_outA,
    output logic [DW-1:0]        o_data_outB,
    output logic [DW-1:0]        o_data_outC,
    output logic [DW-1:0]        o_data_outD,
    output logic                 o_last_end,
    input  logic                 i_finish_in,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_ovf
);

    localparam int CW = $clog2(ROWS_MAX + 1);
    localparam int IW = $clog2(ROWS_MAX);
    localparam int RW = 4 * DW;

    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_FOUR = CW'(4);
    localparam logic [CW-1:0] C_MAX  = CW'(ROWS_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_FEED,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_idx;
    logic            r_clrCnt;
    logic [1:0]      r_waitCnt;
    logic            r_qrRstN;
    logic [RW-1:0]   r_lanes;
    logic            r_lastEnd;
    logic            r_busy;
    logic            r_done;
    logic            r_ovf;
    logic [RW-1:0]   r_mem [ROWS_MAX];

    state_t          w_stateNext;
    logic [CW-1:0]   w_countNext;
    logic [CW-1:0]   w_countPlus;
    logic [CW-1:0]   w_idxNext;
    logic            w_clrCntNext;
    logic [1:0]      w_waitCntNext;
    logic            w_qrRstNNext;
    logic [RW-1:0]   w_lanesNext;
    logic            w_lastEndNext;
    logic            w_doneNext;
    logic            w_ovfNext;
    logic            w_emit;
    logic            w_accept;
    logic            w_loading;
    logic [CW-1:0]   w_nOut;
    logic [RW-1:0]   w_feedRow;

    // s_ready is the only combinational output; it is forced low while in reset.
    assign w_loading   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign s_if.s_ready = reset && w_loading && (r_count < C_MAX);
    assign w_accept    = s_if.s_valid && s_if.s_ready;
    assign w_countPlus = r_count + C_ONE;

    // Short matrices are padded with zero rows so the array always sees four.
    assign w_nOut    = (r_count < C_FOUR) ? C_FOUR : r_count;
    assign w_feedRow = (r_idx < r_count) ? r_mem[r_idx[IW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_count[IW-1:0]] <= s_if.s_data;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_countNext   = r_count;
        w_idxNext     = r_idx;
        w_clrCntNext  = r_clrCnt;
        w_waitCntNext = r_waitCnt;
        w_qrRstNNext  = 1'b1;
        w_lanesNext   = '0;
        w_lastEndNext = 1'b0;
        w_doneNext    = 1'b0;
        w_ovfNext     = r_ovf;
        w_emit        = 1'b0;

        case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_accept) begin
                    w_countNext = w_countPlus;
                    if (s_if.s_last || (w_countPlus == C_MAX)) begin
                        w_stateNext  = S_CLR;
                        w_qrRstNNext = 1'b0;
                        w_clrCntNext = 1'b0;
                        w_idxNext    = '0;
                        if (!s_if.s_last) begin
                            w_ovfNext = 1'b1;
                        end
                    end else begin
                        w_stateNext = S_LOAD;
                    end
                end
            end

            S_CLR: begin
                if (!r_clrCnt) begin
                    w_clrCntNext = 1'b1;
                    w_qrRstNNext = 1'b0;
                end else begin
                    w_stateNext = S_FEED;
                    w_emit      = 1'b1;
                end
            end

            S_FEED: begin
                if (r_idx == w_nOut) begin
                    w_stateNext   = S_WAIT;
                    w_waitCntNext = 2'd0;
                end else begin
                    w_emit = 1'b1;
                end
            end

            S_WAIT: begin
                // The array's finish flag may still be stale from the previous
                // matrix for a couple of cycles, so it is masked at first.
                if (r_waitCnt != 2'd2) begin
                    w_waitCntNext = r_waitCnt + 2'd1;
                end else if (i_finish_in) begin
                    w_doneNext  = 1'b1;
                    w_countNext = '0;
                    w_stateNext = S_IDLE;
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase

        if (w_emit) begin
            w_lanesNext   = w_feedRow;
            w_lastEndNext = (r_idx == (w_nOut - C_ONE));
            w_idxNext     = r_idx + C_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_idx     <= '0;
            r_clrCnt  <= 1'b0;
            r_waitCnt <= 2'd0;
            r_qrRstN  <= 1'b1;
            r_lanes   <= '0;
            r_lastEnd <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_count   <= w_countNext;
            r_idx     <= w_idxNext;
            r_clrCnt  <= w_clrCntNext;
            r_waitCnt <= w_waitCntNext;
            r_qrRstN  <= w_qrRstNNext;
            r_lanes   <= w_lanesNext;
            r_lastEnd <= w_lastEndNext;
            r_busy    <= (w_stateNext != S_IDLE);
            r_done    <= w_doneNext;
            r_ovf     <= w_ovfNext;
        end
    end

    assign o_qr_rst_n  = r_qrRstN;
    assign o_data_outA = r_lanes[DW-1:0];
    assign o_data_outB = r_lanes[2*DW-1:DW];
    assign o_data_outC = r_lanes[3*DW-1:2*DW];
    assign o_data_outD = r_lanes[4*DW-1:3*DW];
    assign o_last_end  = r_lastEnd;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_qr_row_feeder.sv
// Directed bench for qr_row_feeder: load/clear/feed/wait sequencing, padding,
// overflow, finish masking, irregular valid and asynchronous reset.
module tb_qr_row_feeder;

    localparam int DW       = 13;
    localparam int ROWS_MAX = 8;
    localparam int RW       = 4 * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          qr_rst_n;
    logic [DW-1:0] outA, outB, outC, outD;
    logic          last_end;
    logic          finish_in;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [RW-1:0] lanes;

    int vectors     = 0;
    int miscompares = 0;

    qr_row_feeder_if #(.DW(DW)) sIf ();

    qr_row_feeder #(.DW(DW), .ROWS_MAX(ROWS_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_if        (sIf),
        .o_qr_rst_n  (qr_rst_n),
        .o_data_outA (outA),
        .o_data_outB (outB),
        .o_data_outC (outC),
        .o_data_outD (outD),
        .o_last_end  (last_end),
        .i_finish_in (finish_in),
        .o_busy      (busy),
        .o_done      (done),
        .o_ovf       (ovf)
    );

    assign lanes = {outD, outC, outB, outA};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [RW-1:0] mkRow(input int a, input int b, input int c, input int d);
        logic [DW-1:0] la, lb, lc, ld;
        la = a[DW-1:0];
        lb = b[DW-1:0];
        lc = c[DW-1:0];
        ld = d[DW-1:0];
        return {ld, lc, lb, la};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [RW-1:0] data, input logic last);
        sIf.s_valid = 1'b1;
        sIf.s_data  = data;
        sIf.s_last  = last;
        step();
    endtask

    // Entered in the cycle right after the final accept; leaves in the first WAIT cycle.
    task automatic checkFeed(input string tag, input logic [RW-1:0] rows[$], input int nOut, input logic expOvf);
        logic [RW-1:0] expRow;
        checkOutput({tag, "_clr0_rstn"}, qr_rst_n, 0);
        checkOutput({tag, "_clr0_lanes"}, lanes, 0);
        checkOutput({tag, "_clr0_ready"}, sIf.s_ready, 0);
        step();
        checkOutput({tag, "_clr1_rstn"}, qr_rst_n, 0);
        checkOutput({tag, "_clr1_last"}, last_end, 0);
        for (int i = 0; i < nOut; i++) begin
            step();
            expRow = (i < rows.size()) ? rows[i] : '0;
            checkOutput($sformatf("%s_row%0d_rstn", tag, i), qr_rst_n, 1);
            checkOutput($sformatf("%s_row%0d_lanes", tag, i), lanes, expRow);
            checkOutput($sformatf("%s_row%0d_last", tag, i), last_end, (i == nOut - 1) ? 1 : 0);
        end
        step();
        checkOutput({tag, "_wait_lanes"}, lanes, 0);
        checkOutput({tag, "_wait_last"}, last_end, 0);
        checkOutput({tag, "_wait_busy"}, busy, 1);
        checkOutput({tag, "_ovf"}, ovf, expOvf);
    endtask

    // Entered in the first WAIT cycle; finish is accepted at the third WAIT edge
    // at the earliest, or the fourth when the early pulse is exercised.
    task automatic finishMatrix(input string tag, input logic earlyPulse);
        finish_in = earlyPulse;
        step();
        finish_in = 1'b0;
        checkOutput({tag, "_w1_done"}, done, 0);
        checkOutput({tag, "_w1_busy"}, busy, 1);
        if (earlyPulse) begin
            step();
            checkOutput({tag, "_w2_done"}, done, 0);
            step();
            checkOutput({tag, "_w3_done"}, done, 0);
            finish_in = 1'b1;
            step();
        end else begin
            finish_in = 1'b1;
            step();
            checkOutput({tag, "_w2_done"}, done, 0);
            step();
        end
        finish_in = 1'b0;
        checkOutput({tag, "_done_pulse"}, done, 1);
        checkOutput({tag, "_done_busy"}, busy, 0);
        checkOutput({tag, "_done_ready"}, sIf.s_ready, 1);
        step();
        checkOutput({tag, "_done_end"}, done, 0);
    endtask

    initial begin
        logic [RW-1:0] rows[$];
        int            accepted;
        logic          v;

        reset       = 1'b0;
        finish_in   = 1'b0;
        sIf.s_valid = 1'b0;
        sIf.s_data  = '0;
        sIf.s_last  = 1'b0;
        #1;
        checkOutput("inreset_ready", sIf.s_ready, 0);
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("rst_ready", sIf.s_ready, 1);
        checkOutput("rst_rstn", qr_rst_n, 1);
        checkOutput("rst_lanes", lanes, 0);
        checkOutput("rst_last", last_end, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ovf", ovf, 0);

        // Four rows with s_last; valid stays high through the clear to prove no extra accept.
        rows = {};
        rows.push_back(mkRow(1, 2, 3, 4));
        rows.push_back(mkRow(5, 6, 7, 8));
        rows.push_back(mkRow(-1, -2, -3, -4));
        rows.push_back(mkRow(4095, -4096, 0, 1));
        applyStimulus(rows[0], 1'b0);
        checkOutput("m4_busy_load", busy, 1);
        applyStimulus(rows[1], 1'b0);
        applyStimulus(rows[2], 1'b0);
        applyStimulus(rows[3], 1'b1);
        sIf.s_data = mkRow(99, 99, 99, 99);
        checkFeed("m4", rows, 4, 1'b0);
        sIf.s_valid = 1'b0;
        sIf.s_last  = 1'b0;
        finishMatrix("m4", 1'b1);

        // Two rows, padded with two zero rows.
        rows = {};
        rows.push_back(mkRow(-100, 200, -300, 400));
        rows.push_back(mkRow(11, -12, 13, -14));
        applyStimulus(rows[0], 1'b0);
        applyStimulus(rows[1], 1'b1);
        sIf.s_valid = 1'b0;
        checkFeed("m2", rows, 4, 1'b0);
        finishMatrix("m2", 1'b0);

        // Eight rows without s_last: buffer full forces the end and sets overflow.
        rows = {};
        for (int k = 0; k < 8; k++) begin
            rows.push_back(mkRow(k * 10 + 1, -(k + 1), 100 * k, -4096 + k));
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(rows[k], 1'b0);
        end
        sIf.s_valid = 1'b0;
        checkOutput("m8_ready_full", sIf.s_ready, 0);
        checkOutput("m8_ovf_set", ovf, 1);
        checkFeed("m8", rows, 8, 1'b1);
        finishMatrix("m8", 1'b0);

        // Six rows with s_valid toggled at random.
        rows = {};
        for (int k = 0; k < 6; k++) begin
            rows.push_back(mkRow(7 + k, 200 - k, -3 * k, k));
        end
        accepted = 0;
        for (int c = 0; c < 200 && accepted < 6; c++) begin
            v           = 1'($urandom_range(0, 1));
            sIf.s_valid = v;
            sIf.s_data  = rows[accepted];
            sIf.s_last  = (accepted == 5);
            step();
            if (v) accepted++;
        end
        sIf.s_valid = 1'b0;
        sIf.s_last  = 1'b0;
        checkOutput("m6_accepts", accepted, 6);
        checkFeed("m6", rows, 6, 1'b1);
        finishMatrix("m6", 1'b0);

        // Reset pulse in the middle of FEED.
        rows = {};
        rows.push_back(mkRow(21, 22, 23, 24));
        rows.push_back(mkRow(31, 32, 33, 34));
        rows.push_back(mkRow(41, 42, 43, 44));
        rows.push_back(mkRow(51, 52, 53, 54));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(rows[k], (k == 3));
        end
        sIf.s_valid = 1'b0;
        sIf.s_last  = 1'b0;
        step();
        step();
        step();
        checkOutput("mr_row1_lanes", lanes, rows[1]);
        reset = 1'b0;
        #1;
        checkOutput("mr_inreset_lanes", lanes, 0);
        checkOutput("mr_inreset_rstn", qr_rst_n, 1);
        checkOutput("mr_inreset_busy", busy, 0);
        checkOutput("mr_inreset_ready", sIf.s_ready, 0);
        checkOutput("mr_inreset_ovf", ovf, 0);
        step();
        reset = 1'b1;
        #1;
        checkOutput("mr_ready", sIf.s_ready, 1);
        for (int c = 0; c < 8; c++) begin
            step();
            checkOutput($sformatf("mr_idle%0d_lanes", c), lanes, 0);
            checkOutput($sformatf("mr_idle%0d_last", c), last_end, 0);
            checkOutput($sformatf("mr_idle%0d_busy", c), busy, 0);
            checkOutput($sformatf("mr_idle%0d_rstn", c), qr_rst_n, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
